// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall encoding,
// memory-op codes, FSM states and the latched EX->MEM bundle layout.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 172;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_ID_WD = 38;
    localparam int StallBus     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic [31:0] pc;
        logic [3:0]  mem_op;
        logic [31:0] store_data;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load extraction: picks the addressed byte/half out of the load buffer and
// sign- or zero-extends it according to the load op.
module mem_load_ext (
    input  logic [31:0] lbuf,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  mem_op,
    output logic [31:0] ld_val
);
    import mem_stage_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = lbuf[7:0];
        case (addr_lo)
            2'd1:    byte_sel = lbuf[15:8];
            2'd2:    byte_sel = lbuf[23:16];
            2'd3:    byte_sel = lbuf[31:24];
            default: byte_sel = lbuf[7:0];
        endcase
        // addr[0] is ignored for halves; misaligned halves just read the aligned one
        half_sel = addr_lo[1] ? lbuf[31:16] : lbuf[15:0];

        ld_val = 32'd0;
        case (mem_op)
            OP_LB:   ld_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_val = {24'd0, byte_sel};
            OP_LH:   ld_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_val = {16'd0, half_sel};
            OP_LW:   ld_val = lbuf;
            default: ld_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, runs the data-bus handshake and
// produces write-back / decode-bypass buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = mem_stage_pkg::EX_TO_MEM_WD,
    parameter int MEM_TO_WB_WD = mem_stage_pkg::MEM_TO_WB_WD
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [mem_stage_pkg::StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0]                ex_to_mem_bus,
    output logic [MEM_TO_WB_WD-1:0]                mem_to_wb_bus,
    output logic [mem_stage_pkg::MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                                   stallreq_for_mem,
    output logic                                   data_req,
    output logic                                   data_wr,
    output logic [1:0]                             data_size,
    output logic [31:0]                            data_addr,
    output logic [3:0]                             data_wstrb,
    output logic [31:0]                            data_wdata,
    input  logic                                   data_addr_ok,
    input  logic                                   data_data_ok,
    input  logic [31:0]                            data_rdata
);
    import mem_stage_pkg::*;

    ex_to_mem_t reg_q, reg_d, ex_in;
    mem_state_e state_q, state_d;
    logic [31:0] lbuf_q, lbuf_d;

    logic load_en, clear_en, is_ld, is_st, pending, rf_we_out;
    logic [31:0] ld_val, rf_wdata;

    assign ex_in    = ex_to_mem_bus;
    assign load_en  = (stall[3] == NoStop);
    assign clear_en = (stall[3] == Stop) && (stall[4] == NoStop);

    always_comb begin
        reg_d   = reg_q;
        state_d = state_q;
        lbuf_d  = lbuf_q;
        if (load_en) begin
            reg_d   = ex_in;
            lbuf_d  = 32'd0;
            state_d = (op_is_load(ex_in.mem_op) || op_is_store(ex_in.mem_op)) ? S_REQ : S_IDLE;
        end else if (clear_en) begin
            reg_d   = '0;
            lbuf_d  = 32'd0;
            state_d = S_IDLE;
        end else begin
            // handshakes arriving in IDLE/DONE fall through to the default and are dropped
            case (state_q)
                S_REQ: begin
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state_d = S_DONE;
                            lbuf_d  = data_rdata;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        lbuf_d  = data_rdata;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q   <= '0;
            state_q <= S_IDLE;
            lbuf_q  <= 32'd0;
        end else begin
            reg_q   <= reg_d;
            state_q <= state_d;
            lbuf_q  <= lbuf_d;
        end
    end

    assign is_ld            = op_is_load(reg_q.mem_op);
    assign is_st            = op_is_store(reg_q.mem_op);
    assign pending          = (state_q == S_REQ) || (state_q == S_WAIT);
    assign stallreq_for_mem = pending;
    assign data_req         = (state_q == S_REQ);
    assign data_wr          = is_st;
    assign data_addr        = reg_q.ex_result;

    always_comb begin
        data_size  = 2'd0;
        data_wstrb = 4'b0000;
        data_wdata = 32'd0;
        case (reg_q.mem_op)
            OP_LH, OP_LHU: data_size = 2'd1;
            OP_LW:         data_size = 2'd2;
            OP_SB: begin
                data_wstrb = 4'b0001 << reg_q.ex_result[1:0];
                data_wdata = {4{reg_q.store_data[7:0]}};
            end
            OP_SH: begin
                data_size  = 2'd1;
                data_wstrb = reg_q.ex_result[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{reg_q.store_data[15:0]}};
            end
            OP_SW: begin
                data_size  = 2'd2;
                data_wstrb = 4'b1111;
                data_wdata = reg_q.store_data;
            end
            default: data_size = 2'd0;
        endcase
    end

    mem_load_ext u_load_ext (
        .lbuf    (lbuf_q),
        .addr_lo (reg_q.ex_result[1:0]),
        .mem_op  (reg_q.mem_op),
        .ld_val  (ld_val)
    );

    // a load's write-back is not valid until its data has arrived
    assign rf_we_out = reg_q.rf_we & ~(is_ld & pending);
    assign rf_wdata  = is_ld ? ld_val : reg_q.ex_result;

    assign mem_to_wb_bus = {reg_q.hi_we, reg_q.hi_wdata, reg_q.lo_we, reg_q.lo_wdata,
                            reg_q.pc, rf_we_out, reg_q.rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we_out, reg_q.rf_waddr, rf_wdata};

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter EX_TO_MEM_WD, default 172, width of ex_to_mem_bus.
REQ-002 Parameter MEM_TO_WB_WD, default 136, width of mem_to_wb_bus.
REQ-003 Clocking: clock clk; reset rst, synchronous, active-high.
REQ-004 Ports, each name/direction/width/meaning:
- clk in 1: clock.
- rst in 1: sync reset.
- stall in 6: pipeline stall vector; Stop=1.
- ex_to_mem_bus in 172: {hi_we, hi_wdata[32], lo_we, lo_wdata[32], pc[32], mem_op[4], store_data[32], rf_we, rf_waddr[5], ex_result[32]}.
- mem_to_wb_bus out 136: {hi_we, hi_wdata, lo_we, lo_wdata, pc, rf_we, rf_waddr, rf_wdata}.
- mem_to_id_bus out 38: {rf_we, rf_waddr, rf_wdata}, bypass to decode.
- stallreq_for_mem out 1: MEM requests pipeline hold.
- data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wstrb out 4, data_wdata out 32: data-bus request.
- data_addr_ok in 1, data_data_ok in 1, data_rdata in 32: data-bus responses.

Function
REQ-005 Input register: clear to 0 when stall[3]=Stop and stall[4]=NoStop; load ex_to_mem_bus when stall[3]=NoStop; otherwise hold.
REQ-006 mem_op encoding: 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW; every other code means no memory access.
REQ-007 FSM states: IDLE, REQ, WAIT, DONE.
- On a register load whose mem_op is a load or store, next state is REQ.
- On any other load, or on a clear, next state is IDLE.
REQ-008 In REQ, data_req=1.
- addr_ok=1 and data_ok=0: go to WAIT.
- addr_ok=1 and data_ok=1 in the same cycle: go directly to DONE.
- Otherwise stay in REQ, holding all request signals stable.
REQ-009 In WAIT, data_req=0; data_ok=1 moves to DONE.
REQ-010 On the data_ok cycle, data_rdata is captured into a 32-bit load buffer; the buffer holds until the next register load.
REQ-011 data_ok or addr_ok seen in IDLE or DONE is ignored.
REQ-012 stallreq_for_mem = (state==REQ) or (state==WAIT), combinational; it is 0 in IDLE and DONE.
REQ-013 data_addr = ex_result; data_wr=1 for stores only.
- data_size: 0 for B, 1 for H, 2 for W.
REQ-014 Store strobes and data:
- SB: wstrb = 1<<addr[1:0], wdata = byte replicated x4.
- SH: wstrb = addr[1] ? 1100 : 0011, wdata = half replicated x2.
- SW: wstrb = 1111.
- Loads drive wstrb = 0000.
REQ-015 Load extraction from the buffer:
- Byte select = addr[1:0]; half select = addr[1], with addr[0] ignored.
- LB and LH sign-extend; LBU and LHU zero-extend.
- No misalignment exception is raised.
REQ-016 rf_wdata = extracted load value for loads, else ex_result; other mem_to_wb_bus fields pass through from the register.
REQ-017 Output validity:
- mem_to_wb_bus and mem_to_id_bus are fully combinational from register, state and buffer.
- While a load is in REQ or WAIT, rf_we is forced to 0 on both buses.

Reset
REQ-018 Reset effects: register = 0, state = IDLE, buffer = 0.
- data_req=0, stallreq_for_mem=0; all bus outputs are 0.
REQ-019 Reset asserted mid-transaction (REQ/WAIT) returns to IDLE next cycle; the pending response is discarded.

Structure
REQ-020 Shared header holds bus widths (EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD, StallBus), Stop/NoStop, mem_op codes and FSM state codes.
REQ-021 One sub-module, mem_load_ext: combinational byte/half select and extend (buffer, addr[1:0], mem_op -> 32-bit value).

Verification
REQ-022 LW at 0x100, addr_ok in cycle 1, data_ok in cycle 3 with rdata 0xDEADBEEF:
- stallreq high 3 cycles.
- rf_wdata = 0xDEADBEEF with rf_we=1 in DONE.
REQ-023 LB at addr[1:0]=3, rdata 0x80123456 gives rf_wdata 0xFFFFFF80; LBU on the same data gives 0x00000080.
REQ-024 SB at addr 0x102 with store_data 0x000000AB gives wstrb 0100, wdata 0xABABABAB, data_wr=1, size 0.
REQ-025 SH at addr 0x2 gives wstrb 1100.
REQ-026 addr_ok and data_ok in the same cycle as REQ: DONE next cycle, stallreq high exactly 1 cycle.
REQ-027 Stall and reset cases:
- stall[3]=Stop, stall[4]=NoStop: register cleared, all outputs 0.
- rst during WAIT, then a late data_ok: state IDLE, buffer stays 0.
